// File: rtl/param_decoder.sv
// Soft-symbol NRZ decoder with I/Q demux, self-synchronising derandomizer and output shaping.
// Define PARAM_DECODER_FIFO_EN to buffer words in a DEPTH-entry FIFO; otherwise each word is a 1-clk strobe.
module param_decoder #(
    parameter int SOFT_W = 3,
    parameter int DEPTH  = 16,
    parameter int PN_TAP = 13
) (
    input  logic                      clk,
    input  logic                      rs,
    input  logic                      symb_clk_en,
    input  logic                      symb_clk_2x_en,
    input  logic [SOFT_W-1:0]         symb_i,
    input  logic [SOFT_W-1:0]         symb_q,
    input  logic [1:0]                mode,
    input  logic                      demux,
    input  logic                      swap,
    input  logic                      derandomize,
    input  logic                      data_inv,
    input  logic                      sign_mag,
    input  logic                      fifo_rs,
    output logic [2*SOFT_W-1:0]       dout_data,
    output logic                      dout_valid,
    input  logic                      dout_ready,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic                      overflow
);

    localparam int MSB = SOFT_W - 1;

    logic [SOFT_W-1:0]   r_sym_i, r_sym_q;
    logic                r_prev_i, r_prev_q;
    logic [1:0]          r_mode;
    logic                r_demux, r_swap, r_derand, r_inv, r_sm;
    logic                r_first_v, r_second_v, r_half2_pend;
    logic [14:0]         r_lfsr_i, r_lfsr_q;

    logic                w_word_v, w_sel_q, w_pn_i, w_pn_q;
    logic [SOFT_W-1:0]   w_dec_i, w_dec_q, w_fi, w_fq, w_di, w_dq, w_oi, w_oq;
    logic [2*SOFT_W-1:0] w_word;

    function automatic logic nrz_hard(input logic [1:0] m, input logic cur, input logic prev);
        case (m)
            2'b01:   return cur ^ prev;
            2'b10:   return ~(cur ^ prev);
            default: return cur;
        endcase
    endfunction

    function automatic logic [SOFT_W-1:0] shape(input logic [SOFT_W-1:0] f, input logic inv,
                                                input logic sm);
        logic [SOFT_W-1:0] g;
        g = inv ? ~f : f;
        if (!sm) g[MSB-1:0] = g[MSB-1:0] ^ {MSB{~g[MSB]}};
        return g;
    endfunction

    // Controls are sampled with the symbol so a word never mixes two configurations.
    always_ff @(posedge clk or posedge rs) begin
        if (rs) begin
            r_sym_i      <= '0;
            r_sym_q      <= '0;
            r_prev_i     <= 1'b0;
            r_prev_q     <= 1'b0;
            r_mode       <= 2'b00;
            r_demux      <= 1'b0;
            r_swap       <= 1'b0;
            r_derand     <= 1'b0;
            r_inv        <= 1'b0;
            r_sm         <= 1'b0;
            r_first_v    <= 1'b0;
            r_second_v   <= 1'b0;
            r_half2_pend <= 1'b0;
        end else begin
            r_first_v  <= 1'b0;
            r_second_v <= 1'b0;
            if (symb_clk_en) begin
                r_sym_i      <= symb_i;
                r_sym_q      <= symb_q;
                r_prev_i     <= r_sym_i[MSB];
                r_prev_q     <= r_sym_q[MSB];
                r_mode       <= mode;
                r_demux      <= demux;
                r_swap       <= swap;
                r_derand     <= derandomize;
                r_inv        <= data_inv;
                r_sm         <= sign_mag;
                r_first_v    <= 1'b1;
                r_half2_pend <= demux;
            end else if (symb_clk_2x_en && r_half2_pend) begin
                r_second_v   <= 1'b1;
                r_half2_pend <= 1'b0;
            end
        end
    end

    always_comb begin
        w_word_v = r_first_v | r_second_v;
        w_dec_i  = {nrz_hard(r_mode, r_sym_i[MSB], r_prev_i), r_sym_i[MSB-1:0]};
        w_dec_q  = {nrz_hard(r_mode, r_sym_q[MSB], r_prev_q), r_sym_q[MSB-1:0]};
        w_sel_q  = r_second_v ? ~r_swap : r_swap;
        if (r_demux) begin
            w_fi = w_sel_q ? w_dec_q : w_dec_i;
            w_fq = '0;
        end else begin
            w_fi = w_dec_i;
            w_fq = w_dec_q;
        end
        w_pn_i = w_fi[MSB] ^ r_lfsr_i[14] ^ r_lfsr_i[PN_TAP];
        w_pn_q = w_fq[MSB] ^ r_lfsr_q[14] ^ r_lfsr_q[PN_TAP];
        w_di   = w_fi;
        w_dq   = w_fq;
        if (r_derand) begin
            w_di[MSB] = w_pn_i;
            w_dq[MSB] = w_pn_q;
        end
        w_oi   = shape(w_di, r_inv, r_sm);
        w_oq   = r_demux ? '0 : shape(w_dq, r_inv, r_sm);
        w_word = {w_oi, w_oq};
    end

    // In demux mode the serial stream runs through the I descrambler only.
    always_ff @(posedge clk or posedge rs) begin
        if (rs) begin
            r_lfsr_i <= '0;
            r_lfsr_q <= '0;
        end else if (w_word_v) begin
            r_lfsr_i <= {r_lfsr_i[13:0], w_fi[MSB]};
            if (!r_demux) r_lfsr_q <= {r_lfsr_q[13:0], w_fq[MSB]};
        end
    end

`ifdef PARAM_DECODER_FIFO_EN
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [2*SOFT_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]       r_wr, r_rd;
    logic [CW-1:0]       r_count;
    logic                r_ovf;
    logic                w_pop, w_full, w_push;

    assign w_pop  = (r_count != '0) && dout_ready;
    assign w_full = (r_count == CW'(DEPTH));
    assign w_push = w_word_v && (!w_full || w_pop);

    always_ff @(posedge clk or posedge rs) begin
        if (rs) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (fifo_rs) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_word_v && !w_push) r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !fifo_rs) r_mem[r_wr] <= w_word;
    end

    assign dout_valid = (r_count != '0);
    assign dout_data  = dout_valid ? r_mem[r_rd] : '0;
    assign fifo_count = r_count;
    assign overflow   = r_ovf;
`else
    logic                r_dout_valid;
    logic [2*SOFT_W-1:0] r_dout_data;
    logic                w_unused;

    always_ff @(posedge clk or posedge rs) begin
        if (rs) begin
            r_dout_valid <= 1'b0;
            r_dout_data  <= '0;
        end else begin
            r_dout_valid <= w_word_v;
            if (w_word_v) r_dout_data <= w_word;
        end
    end

    assign dout_valid = r_dout_valid;
    assign dout_data  = r_dout_data;
    assign fifo_count = '0;
    assign overflow   = 1'b0;
    assign w_unused   = dout_ready ^ fifo_rs;
`endif

endmodule

// File: tb/tb_param_decoder.sv
// Self-checking bench for param_decoder: vector table, hand sequences and a randomized run
// against a bit-history reference model. Works with or without PARAM_DECODER_FIFO_EN.
module tb_param_decoder;

    localparam int SW     = 3;
    localparam int DEPTH  = 4;
    localparam int PN_TAP = 13;

    typedef struct packed {
        logic [1:0] mode;
        logic       demux;
        logic       swap;
        logic       derand;
        logic       inv;
        logic       sm;
    } ctrl_t;

    typedef struct {
        logic [2:0] si;
        logic [2:0] sq;
        ctrl_t      c;
        int         nw;
        logic [5:0] w0;
        logic [5:0] w1;
    } vec_t;

    logic                    clk = 1'b0;
    logic                    rs;
    logic                    symb_clk_en, symb_clk_2x_en;
    logic [SW-1:0]           symb_i, symb_q;
    logic [1:0]              mode;
    logic                    demux, swap, derandomize, data_inv, sign_mag, fifo_rs;
    logic [2*SW-1:0]         dout_data;
    logic                    dout_valid, dout_ready;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic                    overflow;

    int checks = 0;
    int errors = 0;

    logic [5:0] got[$];
    logic [5:0] expq[$];
    logic       hist_i[$];
    logic       hist_q[$];
    logic       m_prev_i, m_prev_q;
    vec_t       vecs[11];

    param_decoder #(.SOFT_W(SW), .DEPTH(DEPTH), .PN_TAP(PN_TAP)) dut (
        .clk(clk), .rs(rs), .symb_clk_en(symb_clk_en), .symb_clk_2x_en(symb_clk_2x_en),
        .symb_i(symb_i), .symb_q(symb_q), .mode(mode), .demux(demux), .swap(swap),
        .derandomize(derandomize), .data_inv(data_inv), .sign_mag(sign_mag), .fifo_rs(fifo_rs),
        .dout_data(dout_data), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Accepted words, sampled mid-cycle.
    always @(negedge clk) begin
`ifdef PARAM_DECODER_FIFO_EN
        if (!rs && dout_valid && dout_ready) got.push_back(dout_data);
`else
        if (!rs && dout_valid) got.push_back(dout_data);
`endif
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    function automatic ctrl_t mk(input logic [1:0] m, input logic dm, input logic sw,
                                 input logic dr, input logic iv, input logic sm);
        ctrl_t c;
        c.mode = m; c.demux = dm; c.swap = sw; c.derand = dr; c.inv = iv; c.sm = sm;
        return c;
    endfunction

    // Reference model: received-bit history per stream, arithmetic shaping.
    function automatic logic derand_step(input bit use_q, input logic b);
        logic a15, at;
        int   n;
        if (!use_q) begin
            n   = hist_i.size();
            a15 = (n >= 15) ? hist_i[n-15] : 1'b0;
            at  = (n >= PN_TAP + 1) ? hist_i[n-PN_TAP-1] : 1'b0;
            hist_i.push_back(b);
        end else begin
            n   = hist_q.size();
            a15 = (n >= 15) ? hist_q[n-15] : 1'b0;
            at  = (n >= PN_TAP + 1) ? hist_q[n-PN_TAP-1] : 1'b0;
            hist_q.push_back(b);
        end
        return b ^ a15 ^ at;
    endfunction

    function automatic logic [2:0] m_shape(input logic [2:0] f, input bit use_q, input ctrl_t c);
        int   v;
        logic d;
        d = derand_step(use_q, f[2]);
        if (c.derand) f[2] = d;
        v = int'(f);
        if (c.inv) v = 7 - v;
        if (!c.sm && v < 4) v = 3 - v;
        return 3'(v);
    endfunction

    function automatic logic m_hard(input logic [1:0] m, input logic cur, input logic prev);
        if (m == 2'd1) return cur ^ prev;
        if (m == 2'd2) return !(cur ^ prev);
        return cur;
    endfunction

    task automatic model_symbol(input logic [2:0] si, input logic [2:0] sq, input ctrl_t c);
        logic [2:0] fi, fq, a, b, ri, rq;
        fi = {m_hard(c.mode, si[2], m_prev_i), si[1:0]};
        fq = {m_hard(c.mode, sq[2], m_prev_q), sq[1:0]};
        m_prev_i = si[2];
        m_prev_q = sq[2];
        if (c.demux) begin
            a = c.swap ? fq : fi;
            b = c.swap ? fi : fq;
            ri = m_shape(a, 1'b0, c);
            expq.push_back({ri, 3'b000});
            rq = m_shape(b, 1'b0, c);
            expq.push_back({rq, 3'b000});
        end else begin
            ri = m_shape(fi, 1'b0, c);
            rq = m_shape(fq, 1'b1, c);
            expq.push_back({ri, rq});
        end
    endtask

    task automatic apply_ctrl(input ctrl_t c);
        mode = c.mode; demux = c.demux; swap = c.swap;
        derandomize = c.derand; data_inv = c.inv; sign_mag = c.sm;
    endtask

    task automatic send_symbol(input logic [2:0] si, input logic [2:0] sq, input ctrl_t c);
        symb_i = si; symb_q = sq;
        apply_ctrl(c);
        model_symbol(si, sq, c);
        symb_clk_en = 1'b1; symb_clk_2x_en = 1'b1; step();
        symb_clk_en = 1'b0; symb_clk_2x_en = 1'b0; step();
        symb_clk_2x_en = 1'b1; step();
        symb_clk_2x_en = 1'b0; step();
    endtask

    task automatic do_reset();
        rs = 1'b1;
        step();
        got.delete(); expq.delete(); hist_i.delete(); hist_q.delete();
        m_prev_i = 1'b0; m_prev_q = 1'b0;
        rs = 1'b0;
        step();
    endtask

    task automatic timing_check(input logic [2:0] si, input string tag);
        symb_i = si; symb_q = 3'b000;
        symb_clk_en = 1'b1; symb_clk_2x_en = 1'b1; step();
        symb_clk_en = 1'b0; symb_clk_2x_en = 1'b0;
        chk({tag, "_valid_early"}, dout_valid, 1'b0);
        step();
        chk({tag, "_valid_at2"}, dout_valid, 1'b1);
        chk({tag, "_ifield_at2"}, dout_data[5:3], si);
        step();
        chk({tag, "_valid_after"}, dout_valid, 1'b0);
`ifndef PARAM_DECODER_FIFO_EN
        chk({tag, "_ifield_held"}, dout_data[5:3], si);
`endif
        idle(2);
    endtask

    initial begin
        ctrl_t      c;
        logic [3:0] exp_m, exp_s;
        logic [5:0] w;
        logic [14:0] t_i, t_q;
        logic       b_i, b_q;

        rs = 1'b1; symb_clk_en = 1'b0; symb_clk_2x_en = 1'b0;
        symb_i = '0; symb_q = '0; mode = 2'b00; demux = 1'b0; swap = 1'b0;
        derandomize = 1'b0; data_inv = 1'b0; sign_mag = 1'b0; fifo_rs = 1'b0; dout_ready = 1'b1;
        m_prev_i = 1'b0; m_prev_q = 1'b0;

        vecs[0]  = '{3'b100, 3'b011, mk(2'b00, 0, 0, 0, 0, 1), 1, 6'b100011, 6'b000000};
        vecs[1]  = '{3'b100, 3'b011, mk(2'b00, 0, 0, 0, 0, 0), 1, 6'b100000, 6'b000000};
        vecs[2]  = '{3'b101, 3'b010, mk(2'b00, 0, 0, 0, 1, 1), 1, 6'b010101, 6'b000000};
        vecs[3]  = '{3'b101, 3'b010, mk(2'b00, 0, 0, 0, 1, 0), 1, 6'b001101, 6'b000000};
        vecs[4]  = '{3'b110, 3'b001, mk(2'b01, 0, 0, 0, 0, 1), 1, 6'b110001, 6'b000000};
        vecs[5]  = '{3'b110, 3'b001, mk(2'b10, 0, 0, 0, 0, 1), 1, 6'b010101, 6'b000000};
        vecs[6]  = '{3'b011, 3'b111, mk(2'b11, 0, 0, 0, 0, 1), 1, 6'b011111, 6'b000000};
        vecs[7]  = '{3'b100, 3'b011, mk(2'b00, 1, 0, 0, 0, 1), 2, 6'b100000, 6'b011000};
        vecs[8]  = '{3'b100, 3'b011, mk(2'b00, 1, 1, 0, 0, 1), 2, 6'b011000, 6'b100000};
        vecs[9]  = '{3'b100, 3'b011, mk(2'b00, 1, 0, 0, 0, 0), 2, 6'b100000, 6'b000000};
        vecs[10] = '{3'b111, 3'b000, mk(2'b00, 0, 0, 1, 0, 1), 1, 6'b111000, 6'b000000};

        // Outputs while held in reset.
        idle(3);
        chk("rst_valid", dout_valid, 1'b0);
        chk("rst_data", dout_data, 6'd0);
        chk("rst_count", fifo_count, 3'd0);
        chk("rst_ovf", overflow, 1'b0);
        rs = 1'b0;
        step();

        // Single-symbol vectors from a clean reset.
        foreach (vecs[v]) begin
            do_reset();
            send_symbol(vecs[v].si, vecs[v].sq, vecs[v].c);
            idle(4);
            chk($sformatf("vec%0d_nwords", v), got.size(), vecs[v].nw);
            w = (got.size() > 0) ? got[0] : 6'bx;
            chk($sformatf("vec%0d_w0", v), w, vecs[v].w0);
            if (vecs[v].nw == 2) begin
                w = (got.size() > 1) ? got[1] : 6'bx;
                chk($sformatf("vec%0d_w1", v), w, vecs[v].w1);
            end
        end

        // Two-cycle latency and single-cycle strobe.
        do_reset();
        apply_ctrl(mk(2'b00, 0, 0, 0, 0, 1));
        timing_check(3'b100, "lat_a");
        timing_check(3'b011, "lat_b");

        // Differential decoding from prev=0.
        exp_m = 4'b1010;
        exp_s = 4'b0101;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            c = mk((pass == 0) ? 2'b01 : 2'b10, 0, 0, 0, 0, 1);
            send_symbol(3'b100, 3'b000, c);
            send_symbol(3'b100, 3'b000, c);
            send_symbol(3'b000, 3'b000, c);
            send_symbol(3'b000, 3'b000, c);
            idle(4);
            chk($sformatf("nrz%0d_nwords", pass), got.size(), 4);
            for (int k = 0; k < 4; k++) begin
                w = (got.size() > k) ? got[k] : 6'bx;
                chk($sformatf("nrz%0d_bit%0d", pass, k), w[5],
                    (pass == 0) ? exp_m[3-k] : exp_s[3-k]);
            end
        end

        // Derandomizer locks onto an all-zero stream scrambled with taps 14,13.
        do_reset();
        t_i = 15'($urandom_range(1, 32767));
        t_q = 15'($urandom_range(1, 32767));
        c = mk(2'b00, 0, 0, 1, 0, 1);
        for (int k = 0; k < 40; k++) begin
            b_i = t_i[14] ^ t_i[13];
            b_q = t_q[14] ^ t_q[13];
            t_i = {t_i[13:0], b_i};
            t_q = {t_q[13:0], b_q};
            send_symbol({b_i, 2'($urandom)}, {b_q, 2'($urandom)}, c);
        end
        idle(4);
        chk("pn_nwords", got.size(), 40);
        for (int k = 15; k < 40; k++) begin
            w = (got.size() > k) ? got[k] : 6'bx;
            chk($sformatf("pn_w%0d", k), {w[5], w[2]}, 2'b00);
        end

        // Reset between demux halves discards the pair and clears history.
        do_reset();
        apply_ctrl(mk(2'b01, 1, 0, 0, 0, 1));
        symb_i = 3'b100; symb_q = 3'b011;
        symb_clk_en = 1'b1; symb_clk_2x_en = 1'b1; step();
        symb_clk_en = 1'b0; symb_clk_2x_en = 1'b0; step();
        chk("mid_w0_valid", dout_valid, 1'b1);
        chk("mid_w0_data", dout_data, 6'b100000);
        rs = 1'b1;
        #1;
        chk("mid_rst_valid", dout_valid, 1'b0);
        chk("mid_rst_data", dout_data, 6'd0);
        chk("mid_rst_count", fifo_count, 3'd0);
        chk("mid_rst_ovf", overflow, 1'b0);
        symb_clk_2x_en = 1'b1; step();
        rs = 1'b0; step();
        symb_clk_2x_en = 1'b0;
        got.delete(); expq.delete(); hist_i.delete(); hist_q.delete();
        m_prev_i = 1'b0; m_prev_q = 1'b0;
        idle(4);
        chk("mid_no_half2", got.size(), 0);
        send_symbol(3'b100, 3'b011, mk(2'b01, 1, 0, 0, 0, 1));
        idle(4);
        chk("mid_next_nwords", got.size(), 2);
        w = (got.size() > 0) ? got[0] : 6'bx;
        chk("mid_next_w0", w, 6'b100000);
        w = (got.size() > 1) ? got[1] : 6'bx;
        chk("mid_next_w1", w, 6'b011000);

`ifdef PARAM_DECODER_FIFO_EN
        // Overflow, retention of the first DEPTH words, and synchronous flush.
        do_reset();
        dout_ready = 1'b0;
        c = mk(2'b00, 0, 0, 0, 0, 1);
        for (int k = 0; k < 6; k++) send_symbol(3'(k), 3'(7 - k), c);
        idle(3);
        chk("fifo_full_count", fifo_count, 3'd4);
        chk("fifo_full_ovf", overflow, 1'b1);
        chk("fifo_full_valid", dout_valid, 1'b1);
        dout_ready = 1'b1;
        idle(6);
        chk("fifo_drain_n", got.size(), 4);
        for (int k = 0; k < 4; k++) begin
            w = (got.size() > k) ? got[k] : 6'bx;
            chk($sformatf("fifo_drain_w%0d", k), w, expq[k]);
        end
        chk("fifo_ovf_sticky", overflow, 1'b1);
        dout_ready = 1'b0;
        send_symbol(3'b001, 3'b010, c);
        send_symbol(3'b011, 3'b100, c);
        idle(2);
        chk("fifo_pre_flush", fifo_count, 3'd2);
        fifo_rs = 1'b1; step();
        fifo_rs = 1'b0;
        chk("fifo_flush_count", fifo_count, 3'd0);
        chk("fifo_flush_ovf", overflow, 1'b0);
        chk("fifo_flush_valid", dout_valid, 1'b0);
        dout_ready = 1'b1;
`else
        // Without the FIFO, dout_ready is ignored and the status outputs stay low.
        do_reset();
        dout_ready = 1'b0;
        c = mk(2'b00, 0, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) send_symbol(3'(k + 2), 3'(k), c);
        idle(4);
        chk("nofifo_words", got.size(), 3);
        chk("nofifo_count", fifo_count, 3'd0);
        chk("nofifo_ovf", overflow, 1'b0);
        dout_ready = 1'b1;
`endif

        // Randomized symbols and per-symbol configuration against the model.
        do_reset();
        for (int n = 0; n < 250; n++) begin
            c = mk(2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom));
`ifndef PARAM_DECODER_FIFO_EN
            dout_ready = 1'($urandom);
`endif
            send_symbol(3'($urandom), 3'($urandom), c);
        end
        idle(6);
        chk("rnd_nwords", got.size(), expq.size());
        for (int k = 0; k < expq.size(); k++) begin
            w = (got.size() > k) ? got[k] : 6'bx;
            chk($sformatf("rnd_w%0d", k), w, expq[k]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_decoder.md
PARAM_DECODER -- requirements
Module: param_decoder

Interface
REQ-001 Parameter SOFT_W, default 3: soft-symbol width; MSB = hard decision (sign), lower bits = magnitude; legal 2..8.
REQ-002 Parameter DEPTH, default 16: output FIFO depth in words; power of 2, 4..256.
REQ-003 Parameter PN_TAP, default 13: second LFSR feedback tap of the derandomizer; first tap fixed at 14 (15-stage register).
REQ-004 Port clk, in, 1: single clock. All logic in this one domain.
REQ-005 Port rs, in, 1: reset, asynchronous, active-high.
REQ-006 Ports symb_clk_en and symb_clk_2x_en, in, 1 each: symbol-rate and 2x-rate enables; every symb_clk_en pulse coincides with a symb_clk_2x_en pulse.
REQ-007 Ports symb_i and symb_q, in, SOFT_W each: soft symbols, valid on symb_clk_en cycles.
REQ-008 Control ports, in, 1 each (mode is 2 bits), quasi-static: mode[1:0], demux, swap, derandomize, data_inv, sign_mag, fifo_rs.
REQ-009 Port dout_data, out, 2*SOFT_W: output word {I,Q}.
REQ-010 Ports dout_valid (out, 1) and dout_ready (in, 1): output handshake.
REQ-011 Ports fifo_count (out, clog2(DEPTH)+1) and overflow (out, 1): FIFO occupancy and sticky drop flag.

Function
REQ-012 Input capture: on each symb_clk_en cycle, register symb_i and symb_q, and store the previous captured hard bits per channel.
REQ-013 mode: 00 and 11 select NRZ-L (hard bit passed through); 01 selects NRZ-M (hard = cur^prev); 10 selects NRZ-S (hard = ~(cur^prev)). Magnitude bits always come from the current symbol.
REQ-014 demux=0: one word {I,Q} is produced per symb_clk_en, 2 clk cycles after the capture cycle.
REQ-015 demux=1, first half of each symbol (symb_clk_en cycle): emit I, or Q when swap=1.
REQ-016 demux=1, second half (the next symb_clk_2x_en cycle without symb_clk_en): emit the other channel.
REQ-017 demux=1 word format: the emitted symbol occupies the I field and the Q field is zero.
REQ-018 Derandomizer: 15-bit self-synchronising LFSR s, updated per emitted I hard bit b. out = b^s[14]^s[PN_TAP]; then s <= {s[13:0], b}. When derandomize=1 the I hard bit is replaced by out and the Q hard bit by its own LFSR equivalent; the LFSRs shift regardless of derandomize.
REQ-019 data_inv=1 inverts every bit of both soft fields after derandomization.
REQ-020 sign_mag=1 outputs sign-magnitude unchanged. sign_mag=0 outputs offset-binary: magnitude bits are inverted where the sign bit is 0.
REQ-021 Control changes take effect at the next symb_clk_en; no partial words are produced.

Reset
REQ-022 rs=1 immediately clears all registers: LFSRs, previous-bit history, demux phase, FIFO pointers, count and overflow.
REQ-023 During reset: dout_valid=0, dout_data=0, fifo_count=0, overflow=0.
REQ-024 rs asserted mid-symbol or mid-demux-pair discards the partial pair. The first post-reset word derives from the first post-reset symb_clk_en.
REQ-025 fifo_rs=1 (synchronous) flushes the FIFO and clears overflow; decode pipeline and LFSRs are unaffected.

Configuration
REQ-026 With PARAM_DECODER_FIFO_EN defined: words enter a DEPTH-entry FIFO.
- dout_valid = not empty; a word pops on dout_valid & dout_ready.
- No fall-through: a push into an empty FIFO is visible 1 cycle later.
- A push when full with no pop drops the word and sets overflow.
- A simultaneous push and pop when full is accepted.
REQ-027 Without PARAM_DECODER_FIFO_EN: each word drives dout_valid high for exactly 1 clk with dout_data held until the next word.
- dout_ready is ignored.
- fifo_count is always 0 and overflow is always 0.

Verification
REQ-028 SOFT_W=3, mode=00, demux=0, I sequence 3'b100, 3'b011 -> dout_data I fields 100, 011, each 2 clk after its symb_clk_en.
REQ-029 mode=01, I hard bits 1,1,0,0 from prev=0 -> decoded hard bits 1,0,1,0; mode=10 with the same stimulus -> 0,1,0,1.
REQ-030 demux=1, swap=0, I=100, Q=011 -> two words, I field 100 then 011, Q field 000; swap=1 -> order reversed.
REQ-031 derandomize=1, input = PN15 (taps 14,13) scrambled all-zeros -> output all-zeros after at most 15 bits.
REQ-032 FIFO_EN, DEPTH=4, dout_ready=0, 6 words -> fifo_count=4, overflow=1, first 4 words retained. fifo_rs -> count 0, overflow 0.
REQ-033 rs pulse between the two halves of a demux pair -> no second-half word; all outputs 0; next symbol decodes with prev=0.
